// File: rtl/dnn_weight_sequencer_if.sv
// dnn_weight_sequencer_if: weight-row input handshake plus the per-layer weight output bus.
// Latency: none, wires only.
// Backpressure: the source holds in_w_valid/in_w_data until out_w_ready; the layer-facing side has none.
interface dnn_weight_sequencer_if #(
  parameter int NumLayers    = 2,
  parameter int MaxNumNerves = 5,
  parameter int M_W_BitSize  = 4
);

  // Upstream weight-row stream
  logic                                         in_w_valid;
  logic [MaxNumNerves-1:0][M_W_BitSize-1:0]     in_w_data;
  logic                                         out_w_ready;

  // Layer-facing weight bus, one-hot layer select
  logic                                         out_w_valid;
  logic [MaxNumNerves-1:0][M_W_BitSize-1:0]     out_w_data;
  logic [NumLayers-1:0]                         out_w_en;

  // Environment side: drives rows, observes the routed bus
  modport master (
    output in_w_valid,
    output in_w_data,
    input  out_w_ready,
    input  out_w_valid,
    input  out_w_data,
    input  out_w_en
  );

  // Sequencer side
  modport slave (
    input  in_w_valid,
    input  in_w_data,
    output out_w_ready,
    output out_w_valid,
    output out_w_data,
    output out_w_en
  );

endinterface

// File: rtl/dnn_weight_sequencer.sv
// dnn_weight_sequencer: routes one weight-row stream to NumLayers layers in order, masking lanes and truncating bits per layer.
// Latency: 1 cycle from an accepted row to out_w_valid/out_w_en/out_w_data; loaded/rel/ready flags update on registered state.
// Backpressure: out_w_ready only in LOAD, dropped for a 1-cycle layer-switch gap; no backpressure from layers.
// Optional: define DNN_WSEQ_RELOAD_EN to add in_reload for reloading a single layer from DONE.
module dnn_weight_sequencer #(
  parameter int NumLayers               = 2,
  parameter int MaxNumNerves            = 5,
  parameter int M_W_BitSize             = 4,
  parameter int FirstNumIn              = 4,
  parameter int LNN [NumLayers-1:0]     = '{2, 5},
  parameter int LWB [NumLayers-1:0]     = '{4, 2}
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  in_start,
`ifdef DNN_WSEQ_RELOAD_EN
  input  logic [NumLayers-1:0]  in_reload,
`endif
  dnn_weight_sequencer_if.slave w_if,
  output logic [NumLayers-1:0]  out_layer_loaded,
  output logic [NumLayers-1:0]  out_layer_rel,
  output logic                  out_ready
);

  // Layer index and row counter widths; a layer never needs more rows than
  // FirstNumIn or the widest layer.
  localparam int LayerW  = (NumLayers > 1) ? $clog2(NumLayers) : 1;
  localparam int MaxRows = (FirstNumIn > MaxNumNerves) ? FirstNumIn : MaxNumNerves;
  localparam int CntW    = (MaxRows > 1) ? $clog2(MaxRows) : 1;
  localparam logic [LayerW-1:0] LastLayer = LayerW'(NumLayers - 1);

  typedef logic [MaxNumNerves-1:0][M_W_BitSize-1:0] row_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_DONE
  } state_t;

  // Keep the top 'nerves' lanes and the low 'bits' bits of each kept lane.
  function automatic row_t build_mask(input int nerves, input int bits);
    row_t m;
    m = '0;
    for (int k = 0; k < MaxNumNerves; k++) begin
      for (int b = 0; b < M_W_BitSize; b++) begin
        m[k][b] = (k >= MaxNumNerves - nerves) && (b < bits);
      end
    end
    return m;
  endfunction

  // Per-layer constants: lane/bit mask and index of the last row of the layer.
  row_t              layer_mask     [NumLayers];
  logic [CntW-1:0]   layer_last_row [NumLayers];

  for (genvar g = 0; g < NumLayers; g++) begin : g_layer
    // LNN/LWB are listed last layer first, so layer g sits at NumLayers-1-g.
    localparam int Nerves = LNN[NumLayers-1-g];
    localparam int Bits   = LWB[NumLayers-1-g];

    if (Nerves > MaxNumNerves) begin : g_bad_nerves
      $fatal(1, "dnn_weight_sequencer: layer %0d nerve count %0d exceeds MaxNumNerves %0d",
             g, Nerves, MaxNumNerves);
    end
    if (Bits > M_W_BitSize) begin : g_bad_bits
      $fatal(1, "dnn_weight_sequencer: layer %0d weight bitsize %0d exceeds M_W_BitSize %0d",
             g, Bits, M_W_BitSize);
    end

    assign layer_mask[g] = build_mask(Nerves, Bits);

    // Layer 0 takes one row per flattened input; every later layer takes one
    // row per nerve of the layer feeding it.
    if (g == 0) begin : g_first
      assign layer_last_row[g] = CntW'(FirstNumIn - 1);
    end else begin : g_next
      assign layer_last_row[g] = CntW'(LNN[NumLayers-g] - 1);
    end
  end

  // Registered state and outputs
  state_t                 state_q;
  logic [LayerW-1:0]      layer_q;
  logic [CntW-1:0]        cnt_q;
  logic                   w_ready_q;
  logic [NumLayers-1:0]   loaded_q;
  logic [NumLayers-1:0]   rel_q;
  logic                   ready_q;
  logic                   single_q;
  logic                   w_valid_q;
  logic [NumLayers-1:0]   w_en_q;
  row_t                   w_data_q;

  row_t                   cur_mask;
  logic [CntW-1:0]        cur_last;
  logic                   hs;
  logic                   reload_go;
  logic [LayerW-1:0]      reload_layer;

  assign cur_mask = layer_mask[layer_q];
  assign cur_last = layer_last_row[layer_q];
  assign hs       = w_ready_q & w_if.in_w_valid;

`ifdef DNN_WSEQ_RELOAD_EN
  // Decode a one-hot reload request into the layer to reload.
  always_comb begin
    reload_go    = $onehot(in_reload);
    reload_layer = '0;
    for (int l = 0; l < NumLayers; l++) begin
      if (in_reload[l]) begin
        reload_layer = LayerW'(l);
      end
    end
  end
`else
  assign reload_go    = 1'b0;
  assign reload_layer = '0;
`endif

  // Load sequencing FSM: IDLE -> (LOAD -> GAP) per layer -> DONE, restartable from DONE.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q   <= S_IDLE;
      layer_q   <= '0;
      cnt_q     <= '0;
      w_ready_q <= 1'b0;
      loaded_q  <= '0;
      rel_q     <= '0;
      ready_q   <= 1'b0;
      single_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (in_start) begin
            state_q   <= S_LOAD;
            layer_q   <= '0;
            cnt_q     <= '0;
            w_ready_q <= 1'b1;
            loaded_q  <= '0;
            rel_q     <= '0;
            ready_q   <= 1'b0;
            single_q  <= 1'b0;
          end else if (state_q == S_DONE && reload_go) begin
            // Single-layer reload: only that layer's flags drop.
            state_q                <= S_LOAD;
            layer_q                <= reload_layer;
            cnt_q                  <= '0;
            w_ready_q              <= 1'b1;
            loaded_q[reload_layer] <= 1'b0;
            rel_q[reload_layer]    <= 1'b0;
            ready_q                <= 1'b0;
            single_q               <= 1'b1;
          end
        end
        S_LOAD: begin
          if (hs) begin
            if (cnt_q == cur_last) begin
              loaded_q[layer_q] <= 1'b1;
              rel_q[layer_q]    <= 1'b1;
              cnt_q             <= '0;
              w_ready_q         <= 1'b0;
              state_q           <= S_GAP;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        S_GAP: begin
          if (layer_q == LastLayer || single_q) begin
            state_q <= S_DONE;
            ready_q <= 1'b1;
          end else begin
            layer_q   <= layer_q + LayerW'(1);
            w_ready_q <= 1'b1;
            state_q   <= S_LOAD;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          w_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: each accepted row appears one cycle later, masked, with its layer one-hot.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      w_valid_q <= 1'b0;
      w_en_q    <= '0;
      w_data_q  <= '0;
    end else begin
      w_valid_q <= hs;
      w_en_q    <= hs ? (NumLayers'(1) << layer_q) : '0;
      w_data_q  <= hs ? (w_if.in_w_data & cur_mask) : '0;
    end
  end

  assign w_if.out_w_ready  = w_ready_q;
  assign w_if.out_w_valid  = w_valid_q;
  assign w_if.out_w_en     = w_en_q;
  assign w_if.out_w_data   = w_data_q;
  assign out_layer_loaded  = loaded_q;
  assign out_layer_rel     = rel_q;
  assign out_ready         = ready_q;

endmodule

// File: tb/tb_dnn_weight_sequencer.sv
// tb_dnn_weight_sequencer: randomized and directed stimulus against a schedule-based reference model.
// Latency: model predicts every output for the cycle after each clock edge.
// Backpressure: the bench drives in_w_valid freely; acceptance follows out_w_ready.
module tb_dnn_weight_sequencer;

  localparam int NL = 2;
  localparam int NN = 5;
  localparam int WB = 4;

  typedef logic [NN-1:0][WB-1:0] row_t;

  // Per-layer facts for the default configuration, indexed by layer number.
  localparam int ROWS   [NL] = '{4, 2};
  localparam int NERVES [NL] = '{2, 5};
  localparam int BITS   [NL] = '{4, 2};

  logic            clk = 1'b0;
  logic            res_n = 1'b1;
  logic            in_start = 1'b0;
`ifdef DNN_WSEQ_RELOAD_EN
  logic [NL-1:0]   in_reload = '0;
`endif
  logic [NL-1:0]   out_layer_loaded;
  logic [NL-1:0]   out_layer_rel;
  logic            out_ready;

  dnn_weight_sequencer_if #(.NumLayers(NL), .MaxNumNerves(NN), .M_W_BitSize(WB)) wif ();

  dnn_weight_sequencer #(
    .NumLayers(NL),
    .MaxNumNerves(NN),
    .M_W_BitSize(WB),
    .FirstNumIn(4)
  ) dut (
    .clk(clk),
    .res_n(res_n),
    .in_start(in_start),
`ifdef DNN_WSEQ_RELOAD_EN
    .in_reload(in_reload),
`endif
    .w_if(wif),
    .out_layer_loaded(out_layer_loaded),
    .out_layer_rel(out_layer_rel),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The load is a list of slots: one per row of each layer, then one gap slot.
  typedef struct {
    bit gap;
    int layer;
    bit last;
  } slot_t;

  slot_t          sched[$];
  logic [NL-1:0]  m_loaded = '0;
  logic           m_ready = 1'b0;
  logic           m_w_ready = 1'b0;
  logic           m_valid = 1'b0;
  logic [NL-1:0]  m_en = '0;
  row_t           m_data = '0;

  task automatic plan_layer(input int l);
    for (int i = 0; i < ROWS[l]; i++) begin
      sched.push_back('{gap: 1'b0, layer: l, last: (i == ROWS[l] - 1)});
    end
    sched.push_back('{gap: 1'b1, layer: l, last: 1'b0});
  endtask

  function automatic row_t shape(input row_t r, input int l);
    row_t o;
    o = '0;
    for (int k = 0; k < NN; k++) begin
      if (k >= NN - NERVES[l]) begin
        o[k] = WB'(int'(r[k]) % (1 << BITS[l]));
      end
    end
    return o;
  endfunction

  always @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sched.delete();
      m_loaded  = '0;
      m_ready   = 1'b0;
      m_w_ready = 1'b0;
      m_valid   = 1'b0;
      m_en      = '0;
      m_data    = '0;
    end else begin
      m_valid = 1'b0;
      m_en    = '0;
      m_data  = '0;
      if (sched.size() > 0) begin
        if (!sched[0].gap) begin
          if (wif.in_w_valid) begin
            m_valid = 1'b1;
            m_en    = NL'(1) << sched[0].layer;
            m_data  = shape(wif.in_w_data, sched[0].layer);
            if (sched[0].last) m_loaded[sched[0].layer] = 1'b1;
            void'(sched.pop_front());
          end
        end else begin
          void'(sched.pop_front());
          if (sched.size() == 0) m_ready = 1'b1;
        end
      end else if (in_start) begin
        m_loaded = '0;
        m_ready  = 1'b0;
        for (int l = 0; l < NL; l++) plan_layer(l);
      end
`ifdef DNN_WSEQ_RELOAD_EN
      else if (m_ready && $onehot(in_reload)) begin
        for (int l = 0; l < NL; l++) begin
          if (in_reload[l]) begin
            m_loaded[l] = 1'b0;
            m_ready     = 1'b0;
            plan_layer(l);
          end
        end
      end
`endif
      m_w_ready = (sched.size() > 0) && !sched[0].gap;
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    chk("w_ready", 32'(wif.out_w_ready), 32'(m_w_ready));
    chk("w_valid", 32'(wif.out_w_valid), 32'(m_valid));
    chk("w_en",    32'(wif.out_w_en),    32'(m_en));
    chk("loaded",  32'(out_layer_loaded), 32'(m_loaded));
    chk("rel",     32'(out_layer_rel),   32'(m_loaded));
    chk("ready",   32'(out_ready),       32'(m_ready));
    if (m_valid) chk("w_data", 32'(wif.out_w_data), 32'(m_data));
  end

  // ---------------- beat log for directed checks ----------------
  int             cyc = 0;
  int             q_cyc[$];
  logic [NL-1:0]  q_en[$];
  row_t           q_data[$];
  logic [NL-1:0]  q_loaded[$];
  int             rdy_cyc = -1;

  always @(negedge clk) begin
    cyc++;
    if (wif.out_w_valid) begin
      q_cyc.push_back(cyc);
      q_en.push_back(wif.out_w_en);
      q_data.push_back(wif.out_w_data);
      q_loaded.push_back(out_layer_loaded);
    end
    if (out_ready && rdy_cyc < 0) rdy_cyc = cyc;
  end

  task automatic clear_log();
    q_cyc.delete();
    q_en.delete();
    q_data.delete();
    q_loaded.delete();
    rdy_cyc = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int budget);
    int n;
    n = 0;
    while (!out_ready && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(out_ready), 32'd1);
  endtask

  function automatic row_t rand_row();
    return row_t'($urandom);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    wif.in_w_valid = 1'b0;
    wif.in_w_data  = '0;
    #1 res_n = 1'b0;
    tick();
    tick();
    chk("rst_w_ready", 32'(wif.out_w_ready), 32'd0);
    chk("rst_w_valid", 32'(wif.out_w_valid), 32'd0);
    chk("rst_w_en",    32'(wif.out_w_en),    32'd0);
    chk("rst_loaded",  32'(out_layer_loaded), 32'd0);
    chk("rst_rel",     32'(out_layer_rel),   32'd0);
    chk("rst_ready",   32'(out_ready),       32'd0);
    chk("rst_w_data",  32'(wif.out_w_data),  32'd0);
    res_n = 1'b1;

    // Idle: valid rows are never accepted before a start.
    wif.in_w_valid = 1'b1;
    repeat (3) tick();

    // A: full load, continuous valid, all lanes 0xF.
    clear_log();
    wif.in_w_data = '1;
    pulse_start();
    wait_ready("A_ready_timeout", 50);
    wif.in_w_valid = 1'b0;
    repeat (2) tick();
    chk("A_beats", 32'(q_en.size()), 32'd6);
    for (int i = 0; i < q_en.size() && i < 6; i++) begin
      chk("A_en",   32'(q_en[i]),   (i < 4) ? 32'd1 : 32'd2);
      chk("A_data", 32'(q_data[i]), (i < 4) ? 32'h000FF000 : 32'h00033333);
      chk("A_cyc",  32'(q_cyc[i] - q_cyc[0]), (i < 4) ? 32'(i) : 32'(i + 1));
    end
    if (q_en.size() == 6) begin
      chk("A_loaded_l0", 32'(q_loaded[3]), 32'd1);
      chk("A_loaded_l1", 32'(q_loaded[5]), 32'd3);
      chk("A_ready_cyc", 32'(rdy_cyc - q_cyc[5]), 32'd1);
    end

    // B: restart from DONE, stalled stream, start pulse ignored mid-load.
    pulse_start();
    chk("B_restart_loaded", 32'(out_layer_loaded), 32'd0);
    chk("B_restart_ready",  32'(out_ready),        32'd0);
    clear_log();
    for (int i = 0; i < 100 && !out_ready; i++) begin
      wif.in_w_valid = (i % 3 == 0);
      wif.in_w_data  = rand_row();
      in_start       = (i == 7);
      tick();
    end
    in_start = 1'b0;
    wif.in_w_valid = 1'b0;
    chk("B_ready", 32'(out_ready), 32'd1);
    repeat (2) tick();
    chk("B_beats",  32'(q_en.size()), 32'd6);
    chk("B_loaded", 32'(out_layer_loaded), 32'd3);

    // D: asynchronous reset in the middle of layer 1.
    wif.in_w_valid = 1'b1;
    wif.in_w_data  = rand_row();
    pulse_start();
    n = 0;
    while (wif.out_w_en != 2'b10 && n < 50) begin
      wif.in_w_data = rand_row();
      tick();
      n++;
    end
    chk("D_reach_l1", 32'(wif.out_w_en), 32'd2);
    #3 res_n = 1'b0;
    #1;
    chk("D_w_ready", 32'(wif.out_w_ready), 32'd0);
    chk("D_w_valid", 32'(wif.out_w_valid), 32'd0);
    chk("D_w_en",    32'(wif.out_w_en),    32'd0);
    chk("D_loaded",  32'(out_layer_loaded), 32'd0);
    chk("D_rel",     32'(out_layer_rel),   32'd0);
    chk("D_ready",   32'(out_ready),       32'd0);
    chk("D_w_data",  32'(wif.out_w_data),  32'd0);
    tick();
    tick();
    res_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("D_idle_hold", 32'(wif.out_w_ready), 32'd0);
    end
    pulse_start();
    wait_ready("D_reload_timeout", 50);
    chk("D_full_loaded", 32'(out_layer_loaded), 32'd3);

`ifdef DNN_WSEQ_RELOAD_EN
    // R: single-layer reload from DONE.
    wif.in_w_valid = 1'b1;
    in_reload = 2'b11;
    tick();
    in_reload = '0;
    tick();
    chk("R_bad_ready",  32'(out_ready),        32'd1);
    chk("R_bad_loaded", 32'(out_layer_loaded), 32'd3);
    clear_log();
    in_reload = 2'b10;
    tick();
    in_reload = '0;
    chk("R_loaded", 32'(out_layer_loaded), 32'd1);
    chk("R_ready",  32'(out_ready),        32'd0);
    wait_ready("R_ready_timeout", 50);
    wif.in_w_valid = 1'b0;
    repeat (2) tick();
    chk("R_beats", 32'(q_en.size()), 32'd2);
    for (int i = 0; i < q_en.size(); i++) chk("R_en", 32'(q_en[i]), 32'd2);
    chk("R_loaded_after", 32'(out_layer_loaded), 32'd3);
`endif

    // C: random valid, data and start pulses against the model.
    for (int i = 0; i < 700; i++) begin
      wif.in_w_valid = ($urandom_range(0, 3) != 0);
      wif.in_w_data  = rand_row();
      in_start       = ($urandom_range(0, 24) == 0);
`ifdef DNN_WSEQ_RELOAD_EN
      in_reload      = ($urandom_range(0, 7) == 0) ? NL'($urandom) : '0;
`endif
      tick();
    end
    in_start = 1'b0;
`ifdef DNN_WSEQ_RELOAD_EN
    in_reload = '0;
`endif
    wif.in_w_valid = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dnn_weight_sequencer.md
Name: dnn_weight_sequencer

Overview:
Parametrised weight-load controller for an N-layer fully-connected stack built from systolic_array layers.
- Accepts one stream of weight rows and routes them to each layer in order, one row per input of that layer.
- Masks lanes to the layer's nerve count and truncates each lane to the layer's weight bitsize.
- Generates per-layer load enables and release signals, replacing hand-driven weight_en_posedge, with a restart capability the previous top lacked.

Parameters:
- NumLayers, 2, number of nerve layers.
- MaxNumNerves, 5, lanes in the weight bus.
- M_W_BitSize, 4, maximum weight width per lane.
- FirstNumIn, 4, inputs to layer 0 (flattened ImageSize).
- LNN, '{2, 5}, nerves per layer; layer l uses LNN[NumLayers-1-l].
- LWB, '{4, 2}, weight bitsize per layer; layer l uses LWB[NumLayers-1-l].

Ports:
- clk, in, 1, clock.
- res_n, in, 1, asynchronous active-low reset.
- in_start, in, 1, single-cycle pulse that begins or restarts a full load.
- in_w_valid, in, 1, weight row valid.
- in_w_data, in, [MaxNumNerves-1:0][M_W_BitSize-1:0], weight row.
- out_w_ready, out, 1, row accepted when in_w_valid && out_w_ready.
- out_w_data, out, [MaxNumNerves-1:0][M_W_BitSize-1:0], masked and truncated row.
- out_w_valid, out, 1, out_w_data valid this cycle.
- out_w_en, out, [NumLayers-1:0], one-hot target layer; bit l is layer l.
- out_layer_loaded, out, [NumLayers-1:0], sticky per-layer complete flags.
- out_layer_rel, out, [NumLayers-1:0], level signal, high while layer l is loaded; used as that layer's run-enable/res_n.
- out_ready, out, 1, all layers loaded.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, layer index 0, row count 0. All outputs 0: out_w_ready, out_w_valid, out_w_en, out_layer_loaded, out_layer_rel, out_ready, out_w_data.
- Rows for layer l: R(l) = FirstNumIn for l=0, otherwise the LNN of layer l-1. Defaults give R(0)=4 and R(1)=2, for 6 rows total.
- State IDLE: out_w_ready=0. in_start → LOAD, layer 0, count 0, loaded/rel/out_ready cleared.
- State LOAD: out_w_ready=1.
  - Each handshake increments count.
  - On the handshake with count==R(l)-1: set out_layer_loaded[l] and out_layer_rel[l] on the next cycle, clear count, go to GAP.
- State GAP: exactly 1 cycle with out_w_ready=0 (layer switch bubble).
  - If l==NumLayers-1 → DONE.
  - Otherwise l+1 → LOAD.
- State DONE: out_w_ready=0, out_ready=1. in_start → LOAD as from IDLE, clearing every loaded/rel bit in the same cycle.
- in_start while in LOAD or GAP: ignored.
- Output path registered, latency 1. An accepted row at cycle t gives out_w_valid=1 and out_w_en=onehot(l) at t+1; otherwise both are 0 at t+1.
- Masking: lane k is kept if k >= MaxNumNerves-LNN(l), i.e. the top LNN(l) lanes; other lanes are 0.
- Truncation: each kept lane keeps bits [LWB(l)-1:0]; upper bits are forced to 0.
- Elaboration checks: every LNN(l) <= MaxNumNerves and every LWB(l) <= M_W_BitSize, otherwise $fatal.
- No backpressure from layers: downstream must accept every out_w_valid beat.

Optional Feature:
- Macro DNN_WSEQ_RELOAD_EN adds input in_reload [NumLayers-1:0].
- With the macro: a one-hot pulse on in_reload while in DONE clears that layer's loaded/rel bits and out_ready, then reloads only that layer (LOAD→GAP→DONE).
  - Non-one-hot values are ignored.
  - in_reload is ignored outside DONE.
  - in_start has priority when both arrive in the same cycle.
- Without the macro: the port does not exist, and only a full reload via in_start is possible.

Test Plan:
- Full load at defaults with in_w_valid=1 continuously:
  - out_w_en=2'b01 for 4 beats, 1-cycle gap, then 2'b10 for 2 beats.
  - out_layer_loaded goes 01 then 11; out_ready=1 one cycle after the GAP that follows the last beat.
- Masking and truncation, all lanes 4'hF: layer 0 outputs lanes {F,F,0,0,0}; layer 1 outputs lanes {3,3,3,3,3}.
- Stalls: in_w_valid toggled 1,0,0,1,... → count advances only on handshakes; exactly 6 out_w_valid beats in total.
- in_start pulsed mid-LOAD at row 2 → ignored and the sequence completes normally. in_start in DONE → loaded=00 and out_ready=0 next cycle, then a full reload.
- res_n dropped asynchronously mid-layer-1 → all outputs 0 immediately; after release, the state stays IDLE until in_start.
- With DNN_WSEQ_RELOAD_EN: in_reload=2'b10 in DONE → loaded=01 and 2 beats with out_w_en=2'b10, then out_ready=1 again. in_reload=2'b11 → no effect.
